// File: rtl/wide_add_seq_pkg.sv
// wide_add_pkg: shared constants, FSM state type and index-width helper
// for the wide_add_seq multi-cycle wide-adder sequencer.
package wide_add_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word index width; never narrower than one bit.
  function automatic int idx_w(input int nwords);
    return (nwords > 2) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/wide_add_seq_if.sv
// wide_add_seq_if: operand/result handshake bundle for wide_add_seq.
// master = upstream/downstream side, slave = the sequencer.
// Optional macro WIDE_ADD_OVF_EN adds the ovf result flag.
interface wide_add_seq_if #(
  parameter int NWORDS = 4
);
  localparam int WIDTH = 16 * NWORDS;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef WIDE_ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef WIDE_ADD_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef WIDE_ADD_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/wide_add_seq_word_sel.sv
// word_sel: selects one 16-bit word out of a wide vector by word index.
module word_sel
  import wide_add_pkg::*;
#(
  parameter int NWORDS = 4,
  parameter int IW     = 2
) (
  input  logic [SLICE_W*NWORDS-1:0] data,
  input  logic [IW-1:0]             idx,
  output logic [SLICE_W-1:0]        word
);

  // Priority-free one-hot style mux over the words.
  always_comb begin
    word = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (idx == IW'(i)) word = data[i*SLICE_W +: SLICE_W];
    end
  end

endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: feeds a wide operand pair through an external 16-bit
// adder slice one word per cycle (LSW first), chaining the carry in a
// register and assembling the wide sum. Result handed off valid/ready.
// Optional macro WIDE_ADD_OVF_EN adds a two's-complement overflow flag.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  wide_add_seq_if.slave        bus,
  output logic [SLICE_W-1:0]   add_a,
  output logic [SLICE_W-1:0]   add_b,
  output logic                 add_cin,
  input  logic [SLICE_W-1:0]   add_sum,
  input  logic                 add_cout
);

  localparam int WIDTH = SLICE_W * NWORDS;
  localparam int IW    = idx_w(NWORDS);

  state_t             state_q;
  state_t             state_d;
  logic [IW-1:0]      idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic [SLICE_W-1:0] sel_a;
  logic [SLICE_W-1:0] sel_b;
  logic               last_word;
  logic               accept;
`ifdef WIDE_ADD_OVF_EN
  logic               ovf_q;
`endif

  assign last_word = (idx_q == IW'(NWORDS - 1));
  assign accept    = (state_q == IDLE) && bus.in_valid;

  word_sel #(.NWORDS(NWORDS), .IW(IW)) u_sel_a (
    .data (a_q),
    .idx  (idx_q),
    .word (sel_a)
  );

  word_sel #(.NWORDS(NWORDS), .IW(IW)) u_sel_b (
    .data (b_q),
    .idx  (idx_q),
    .word (sel_b)
  );

  // Slice drive: active only while words are being walked, quiet otherwise.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = sel_a;
      add_b   = sel_b;
      add_cin = carry_q;
    end
  end

  // Next-state logic: DONE never overlaps with accepting a new pair.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last_word)    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture, per-word sum collection and carry chaining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      carry_q <= bus.cin;
      idx_q   <= '0;
`ifdef WIDE_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else if (state_q == RUN) begin
      for (int i = 0; i < NWORDS; i++) begin
        if (idx_q == IW'(i)) sum_q[i*SLICE_W +: SLICE_W] <= add_sum;
      end
      carry_q <= add_cout;
      if (last_word) begin
        cout_q <= add_cout;
        idx_q  <= '0;
`ifdef WIDE_ADD_OVF_EN
        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                  (add_sum[SLICE_W-1] != a_q[WIDTH-1]);
`endif
      end else begin
        idx_q  <= idx_q + IW'(1);
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef WIDE_ADD_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule
